// File: rtl/axi_ram_slave_if.sv
// Single-beat AXI3 bus bundle between a master and axi_ram_slave.
// The slave modport faces the RAM; the master modport faces the initiator.
interface axi_ram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_ram_slave.sv
// Single-outstanding AXI3 RAM responder with fixed response latency.
// Bursts and sizes wider than one word are answered with SLVERR.
module axi_ram_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int DELAY      = 2
) (
  input logic            clk,
  input logic            resetn,
  axi_ram_slave_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_WAIT    = 3'd1,
    RD_RESP    = 3'd2,
    WR_COLLECT = 3'd3,
    WR_WAIT    = 3'd4,
    WR_RESP    = 3'd5
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(DELAY - 1);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   last_wr_q, last_wr_d;
  logic [ADDR_WIDTH-1:0]  rd_idx_q, rd_idx_d;
  logic [3:0]             rid_q, rid_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  logic                   have_aw_q, have_aw_d;
  logic                   have_w_q, have_w_d;
  logic [ADDR_WIDTH-1:0]  aw_idx_q, aw_idx_d;
  logic                   aw_err_q, aw_err_d;
  logic [3:0]             bid_q, bid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic [31:0]            w_data_q, w_data_d;
  logic [3:0]             w_strb_q, w_strb_d;
  logic [31:0]            mem_q [2**ADDR_WIDTH];

  logic                   grant_rd_s, grant_wr_s;
  logic                   arready_s, awready_s, wready_s;
  logic                   ar_hs_s, aw_hs_s, w_hs_s, wr_fire_s, mem_we_s;
  logic                   rd_err_in_s, aw_err_in_s, wr_err_m_s;
  logic [ADDR_WIDTH-1:0]  aw_idx_in_s, wr_idx_m_s;
  logic [31:0]            wr_data_m_s;
  logic [3:0]             wr_strb_m_s;
  logic                   unused_s;

  assign unused_s = ^{bus.arburst, bus.arlock, bus.arcache, bus.arprot,
                      bus.awburst, bus.awlock, bus.awcache, bus.awprot,
                      bus.wid, bus.wlast,
                      bus.araddr[31:ADDR_WIDTH+2], bus.araddr[1:0],
                      bus.awaddr[31:ADDR_WIDTH+2], bus.awaddr[1:0]};

  // When read and write contend, the side not served last wins.
  assign grant_rd_s = resetn & bus.arvalid & (~(bus.awvalid | bus.wvalid) | last_wr_q);
  assign grant_wr_s = resetn & (bus.awvalid | bus.wvalid) & ~grant_rd_s;

  assign rd_err_in_s = (bus.arlen != 8'd0) || (bus.arsize > 3'd2);
  assign aw_err_in_s = (bus.awlen != 8'd0) || (bus.awsize > 3'd2);
  assign aw_idx_in_s = bus.awaddr[ADDR_WIDTH+1:2];

  // Ready generation: only IDLE and WR_COLLECT ever accept anything.
  always_comb begin
    arready_s = 1'b0;
    awready_s = 1'b0;
    wready_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_rd_s) begin
          arready_s = 1'b1;
        end else if (grant_wr_s) begin
          awready_s = 1'b1;
          wready_s  = 1'b1;
        end else begin
          arready_s = 1'b0;
        end
      end
      WR_COLLECT: begin
        awready_s = resetn & ~have_aw_q;
        wready_s  = resetn & ~have_w_q;
      end
      default: begin
        arready_s = 1'b0;
      end
    endcase
  end

  assign ar_hs_s = arready_s & bus.arvalid;
  assign aw_hs_s = awready_s & bus.awvalid;
  assign w_hs_s  = wready_s & bus.wvalid;

  // Merge already-held halves with the ones arriving this cycle.
  assign wr_idx_m_s  = have_aw_q ? aw_idx_q : aw_idx_in_s;
  assign wr_err_m_s  = have_aw_q ? aw_err_q : aw_err_in_s;
  assign wr_data_m_s = have_w_q ? w_data_q : bus.wdata;
  assign wr_strb_m_s = have_w_q ? w_strb_q : bus.wstrb;
  assign wr_fire_s   = ((state_q == IDLE) || (state_q == WR_COLLECT)) &
                       (have_aw_q | aw_hs_s) & (have_w_q | w_hs_s);
  assign mem_we_s    = wr_fire_s & ~wr_err_m_s;

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_wr_d = last_wr_q;
    rd_idx_d  = rd_idx_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    have_aw_d = have_aw_q;
    have_w_d  = have_w_q;
    aw_idx_d  = aw_idx_q;
    aw_err_d  = aw_err_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    if (aw_hs_s) begin
      have_aw_d = 1'b1;
      aw_idx_d  = aw_idx_in_s;
      aw_err_d  = aw_err_in_s;
      bid_d     = bus.awid;
    end else begin
      have_aw_d = have_aw_q;
    end
    if (w_hs_s) begin
      have_w_d = 1'b1;
      w_data_d = bus.wdata;
      w_strb_d = bus.wstrb;
    end else begin
      have_w_d = have_w_q;
    end
    case (state_q)
      IDLE: begin
        if (ar_hs_s) begin
          rd_idx_d  = bus.araddr[ADDR_WIDTH+1:2];
          rid_d     = bus.arid;
          rresp_d   = rd_err_in_s ? 2'b10 : 2'b00;
          cnt_d     = CNT_INIT;
          last_wr_d = 1'b0;
          state_d   = RD_WAIT;
        end else if (wr_fire_s) begin
          bresp_d   = wr_err_m_s ? 2'b10 : 2'b00;
          cnt_d     = CNT_INIT;
          have_aw_d = 1'b0;
          have_w_d  = 1'b0;
          last_wr_d = 1'b1;
          state_d   = WR_WAIT;
        end else if (aw_hs_s | w_hs_s) begin
          last_wr_d = 1'b1;
          state_d   = WR_COLLECT;
        end else begin
          state_d = IDLE;
        end
      end
      WR_COLLECT: begin
        if (wr_fire_s) begin
          bresp_d   = wr_err_m_s ? 2'b10 : 2'b00;
          cnt_d     = CNT_INIT;
          have_aw_d = 1'b0;
          have_w_d  = 1'b0;
          state_d   = WR_WAIT;
        end else begin
          state_d = WR_COLLECT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = mem_q[rd_idx_q];
          state_d = RD_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_RESP: begin
        if (bus.rready) begin
          state_d = IDLE;
        end else begin
          state_d = RD_RESP;
        end
      end
      WR_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = WR_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_RESP: begin
        if (bus.bready) begin
          state_d = IDLE;
        end else begin
          state_d = WR_RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; last-served resets to write so read wins first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_wr_q <= 1'b1;
      rd_idx_q  <= '0;
      rid_q     <= 4'd0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
      have_aw_q <= 1'b0;
      have_w_q  <= 1'b0;
      aw_idx_q  <= '0;
      aw_err_q  <= 1'b0;
      bid_q     <= 4'd0;
      bresp_q   <= 2'b00;
      w_data_q  <= 32'd0;
      w_strb_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
      rd_idx_q  <= rd_idx_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      have_aw_q <= have_aw_d;
      have_w_q  <= have_w_d;
      aw_idx_q  <= aw_idx_d;
      aw_err_q  <= aw_err_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
    end
  end

  // Byte-enabled RAM write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb_m_s[i]) begin
          mem_q[wr_idx_m_s][8*i +: 8] <= wr_data_m_s[8*i +: 8];
        end
      end
    end
  end

  assign bus.arready = arready_s;
  assign bus.awready = awready_s;
  assign bus.wready  = wready_s;
  assign bus.rvalid  = (state_q == RD_RESP);
  assign bus.rlast   = (state_q == RD_RESP);
  assign bus.rid     = rid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.bvalid  = (state_q == WR_RESP);
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;
endmodule
